// File: rtl/seg7_scan_complementer.sv
// Multiplexed multi-digit 7-segment driver: shows each latched digit as hex, BCD or
// nine's complement (optionally with leading-zero blanking), one digit per refresh slot.
module seg7_scan_complementer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [1:0]              mode,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] nines(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_mask_q, dp_mask_d;
  logic [1:0]              mode_q, mode_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic                    tick;
  logic [3:0]              digit;
  logic                    blank;
  logic [NUM_DIGITS:0]     nines_run;

  always_comb begin
    value_d   = load ? value   : value_q;
    dp_mask_d = load ? dp_mask : dp_mask_q;
    mode_d    = load ? mode    : mode_q;

    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A digit's complement is zero exactly when the digit is 9, so blanking
    // reduces to "this digit and every more significant one are all 9".
    nines_run = '0;
    nines_run[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      nines_run[i] = nines_run[i+1] & (value_q[4*i +: 4] == 4'd9);

    digit = value_q[{idx_q, 2'b00} +: 4];
    blank = (mode_q == 2'b11) && (idx_q != '0) && nines_run[idx_q];

    case (mode_q)
      2'b00:   seg_d = hex_glyph(digit);
      2'b01:   seg_d = (digit > 4'd9) ? SEG_DASH : hex_glyph(digit);
      default: seg_d = (digit > 4'd9) ? SEG_DASH : hex_glyph(nines(digit));
    endcase
    if (blank) seg_d = SEG_BLANK;

    an_d    = ~(NUM_DIGITS'(1) << idx_q);
    dp_d    = ~dp_mask_q[idx_q];
    frame_d = tick && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q   <= '0;
      dp_mask_q <= '0;
      mode_q    <= 2'b00;
      div_q     <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      value_q   <= value_d;
      dp_mask_q <= dp_mask_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule
